fifo_rd_ctrl: RTL and testbench
===============================

# fifo_rd_ctrl

Synchronous FIFO controller that drives a `simple_dual_one_clock` RAM instance and converts its 1-cycle registered read into a first-word-fall-through valid/ready stream. Producer pushes into the write port; the controller schedules RAM reads ahead of demand into a 2-entry output buffer so the consumer can pop one word per cycle. The RAM instance and this block are instantiated side by side in the parent and wired port-to-port.

## Interface

Parameters:
- ADDR_WIDTH, 6: RAM address width; DEPTH = 1<<ADDR_WIDTH is the FIFO capacity.
- DATA_WIDTH, 64: word width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  controller accepts a word.
- in_data  in  DATA_WIDTH  producer word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer takes the word.
- out_data  out  DATA_WIDTH  head-of-FIFO word.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_ptr  out  ADDR_WIDTH  RAM write address.
- ram_wr_data  out  DATA_WIDTH  RAM write data.
- ram_rd_en  out  1  RAM read enable.
- ram_rd_ptr  out  ADDR_WIDTH  RAM read address.
- ram_rd_data  in  DATA_WIDTH  RAM read data, valid the cycle after ram_rd_en.
- count  out  ADDR_WIDTH+1  total occupancy (RAM + in flight + output buffer), 0..DEPTH.

## Operation

- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count < DEPTH) & ~rst. It does not depend on out_ready, so there is no pass-through when full.
- Write side: ram_wr_en = push, ram_wr_ptr = wr_ptr, ram_wr_data = in_data (all combinational). wr_ptr increments on push and wraps DEPTH-1 -> 0.
- ram_level register: the number of words written to the RAM but not yet read-issued. Update is +push -issue.
- Output buffer: 2 entries (head, skid) with occupancy buf_cnt 0..2. rd_pending register is 1 if a read was issued last cycle.
- Read issue: issue = (ram_level > 0) & (buf_cnt + rd_pending - pop <= 1).
  - ram_rd_en = issue. ram_rd_ptr = rd_ptr.
  - rd_ptr increments on issue and wraps.
  - rd_pending <= issue.
- Capture: when rd_pending is 1, ram_rd_data is written into the buffer at the tail, after this cycle's pop has shifted skid to head. Buffer order is strictly FIFO.
- out_valid = (buf_cnt != 0). out_data = head entry.
- count: +1 on push, -1 on pop. Simultaneous push and pop leaves count unchanged.
- No address hazard:
  - An address is read only after the edge that wrote it.
  - An address is rewritten only after its word is popped, which count guarantees.
- RAM contents are never cleared. Reset discards them logically.

## Timing

- Reset (async, immediate): wr_ptr = rd_ptr = 0, ram_level = 0, buf_cnt = 0, rd_pending = 0, count = 0.
  - Outputs: out_valid = 0, in_ready = 0, ram_wr_en = 0, ram_rd_en = 0. out_data is don't-care, held at 0.
- First cycle after rst deassertion: in_ready = 1.
- Latency: a word pushed at edge k into an empty FIFO produces:
  - ram_rd_en = 1 in the cycle after edge k,
  - rd_pending = 1 after edge k+1,
  - out_valid = 1 after edge k+2.
- Throughput: 1 push and 1 pop per cycle sustained, with count constant, once the pipeline is primed.
- Full (count = DEPTH): in_ready = 0. A pop at edge k gives in_ready = 1 after edge k.
- Empty (count = 0): out_valid = 0 and ram_rd_en = 0. A push is allowed.
- Backpressure: while out_valid & ~out_ready, out_data holds stable. At most 2 words sit in the buffer plus none in flight beyond the skid slot.
- Reset mid-operation: all state clears asynchronously. No stale word appears after release, even if a RAM read was in flight.

## Test plan

- Reset: assert rst for 3 cycles with in_valid = 1 -> in_ready = 0, ram_wr_en = 0, count = 0, out_valid = 0. After release, in_ready = 1.
- Single word: push 0xA5 at edge k with out_ready = 1 -> ram_wr_en = 1 with ram_wr_ptr = 0 at edge k; ram_rd_en = 1 with ram_rd_ptr = 0 next cycle; out_valid = 1 with out_data = 0xA5 after edge k+2; count returns to 0 after the pop.
- Fill/drain: out_ready = 0, push 0..63 -> count = 64 and in_ready = 0, word 64 is held, out_data = 0. Then out_ready = 1 -> 0..63 emerge in order, one per cycle, and in_ready = 1 after the first pop.
- Streaming wrap: push 200 incrementing words with out_ready = 1 continuously -> after 2-cycle priming, one word out per cycle in order, count stays constant, and both pointers wrap 63 -> 0 three times.
- Random backpressure: in_valid and out_ready each random at 50% over 5000 cycles -> scoreboard shows no loss or duplication, out_data is stable while stalled, and count always matches the scoreboard depth.
- Mid-operation reset: with count = 10 and a read in flight, pulse rst -> all outputs are at reset values immediately. Then push 0x1 -> the first word out is 0x1.

Source files
------------

// File: rtl/fifo_rd_ctrl_if.sv
// Bundle of the producer, consumer and RAM-port signals of fifo_rd_ctrl.
// master = controller side, slave = the parent/environment (RAM + producer + consumer).
interface fifo_rd_ctrl_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_ptr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic                  ram_rd_en;
  logic [ADDR_WIDTH-1:0] ram_rd_ptr;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    input  in_valid, in_data, out_ready, ram_rd_data,
    output in_ready, out_valid, out_data,
    output ram_wr_en, ram_wr_ptr, ram_wr_data, ram_rd_en, ram_rd_ptr, count
  );

  modport slave (
    output in_valid, in_data, out_ready, ram_rd_data,
    input  in_ready, out_valid, out_data,
    input  ram_wr_en, ram_wr_ptr, ram_wr_data, ram_rd_en, ram_rd_ptr, count
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// FIFO controller around a 1-cycle registered-read dual-port RAM, presenting a
// first-word-fall-through stream through a 2-entry (head, skid) output buffer.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64
) (
  input  logic           clk,
  input  logic           rst,
  fifo_rd_ctrl_if.master bus
);
  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  // Handshake: a word moves on a rising edge when valid & ready are both 1;
  // valid never depends on ready, and in_ready never depends on out_ready.

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_level_q, ram_level_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic                  rd_pending_q, rd_pending_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;

  logic       in_ready;
  logic       push;
  logic       pop;
  logic       issue;
  logic [2:0] buf_need;
  logic [1:0] cnt_after_pop;

  always_comb begin
    in_ready = (count_q != DEPTH_C) & ~rst;
    push     = bus.in_valid & in_ready;
    pop      = (buf_cnt_q != 2'd0) & bus.out_ready;
    // Slots the buffer will need next cycle, counting the read already in flight.
    buf_need = {1'b0, buf_cnt_q} + {2'b00, rd_pending_q} - {2'b00, pop};
    issue    = (ram_level_q != '0) & (buf_need <= 3'd1);

    wr_ptr_d     = wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, push};
    rd_ptr_d     = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, issue};
    ram_level_d  = ram_level_q + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, issue};
    count_d      = count_q + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, pop};
    rd_pending_d = issue;

    head_d        = head_q;
    skid_d        = skid_q;
    cnt_after_pop = buf_cnt_q - {1'b0, pop};
    if (pop) begin
      head_d = skid_q;
    end
    // Returning read data lands at the tail after the pop shift.
    if (rd_pending_q) begin
      if (cnt_after_pop == 2'd0) begin
        head_d = bus.ram_rd_data;
      end else begin
        skid_d = bus.ram_rd_data;
      end
    end
    buf_cnt_d = cnt_after_pop + {1'b0, rd_pending_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_level_q  <= '0;
      count_q      <= '0;
      buf_cnt_q    <= '0;
      rd_pending_q <= 1'b0;
      head_q       <= '0;
      skid_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_level_q  <= ram_level_d;
      count_q      <= count_d;
      buf_cnt_q    <= buf_cnt_d;
      rd_pending_q <= rd_pending_d;
      head_q       <= head_d;
      skid_q       <= skid_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (buf_cnt_q != 2'd0);
  assign bus.out_data    = head_q;
  assign bus.ram_wr_en   = push;
  assign bus.ram_wr_ptr  = wr_ptr_q;
  assign bus.ram_wr_data = bus.in_data;
  assign bus.ram_rd_en   = issue;
  assign bus.ram_rd_ptr  = rd_ptr_q;
  assign bus.count       = count_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural RAM beside the DUT, a directed vector
// table, hand-written fill/stream/reset sequences and a random scoreboard run.
module tb_fifo_rd_ctrl;
  localparam int AW = 6;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_rd_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fifo_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---- RAM model: synchronous write, 1-cycle registered read ----
  logic [DW-1:0] mem [1<<AW];
  initial bus.ram_rd_data = '0;
  always @(posedge clk) begin
    if (bus.ram_wr_en) mem[bus.ram_wr_ptr] <= bus.ram_wr_data;
    if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_ptr];
  end

  // ---- scoreboard ----
  int n_vec  = 0;
  int n_miss = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [DW-1:0] id, input logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
  endtask

  // ---- vector table ----
  typedef struct {
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          e_in_ready;
    logic          e_wr_en;
    logic [AW-1:0] e_wr_ptr;
    logic          e_rd_en;
    logic [AW-1:0] e_rd_ptr;
    logic          e_out_valid;
    logic [DW-1:0] e_out_data;
    logic [AW:0]   e_count;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int n_out;
    int n_iss;
    logic stalled;
    logic [DW-1:0] held;
    logic got;

    //        iv  data    ordy  ir  we wp  re rp  ov  od      cnt
    vecs[0]  = '{1, 64'hA5, 1,  1,  1, 0,  0, 0,  0, 64'h0,  0};
    vecs[1]  = '{0, 64'h0,  1,  1,  0, 1,  1, 0,  0, 64'h0,  1};
    vecs[2]  = '{0, 64'h0,  1,  1,  0, 1,  0, 1,  0, 64'h0,  1};
    vecs[3]  = '{0, 64'h0,  1,  1,  0, 1,  0, 1,  1, 64'hA5, 1};
    vecs[4]  = '{0, 64'h0,  1,  1,  0, 1,  0, 1,  0, 64'h0,  0};
    vecs[5]  = '{1, 64'h11, 0,  1,  1, 1,  0, 1,  0, 64'h0,  0};
    vecs[6]  = '{1, 64'h22, 0,  1,  1, 2,  1, 1,  0, 64'h0,  1};
    vecs[7]  = '{1, 64'h33, 0,  1,  1, 3,  1, 2,  0, 64'h0,  2};
    vecs[8]  = '{0, 64'h0,  0,  1,  0, 4,  0, 3,  1, 64'h11, 3};
    vecs[9]  = '{0, 64'h0,  0,  1,  0, 4,  0, 3,  1, 64'h11, 3};
    vecs[10] = '{0, 64'h0,  1,  1,  0, 4,  1, 3,  1, 64'h11, 3};
    vecs[11] = '{0, 64'h0,  1,  1,  0, 4,  0, 4,  1, 64'h22, 2};
    vecs[12] = '{0, 64'h0,  1,  1,  0, 4,  0, 4,  1, 64'h33, 1};
    vecs[13] = '{0, 64'h0,  1,  1,  0, 4,  0, 4,  0, 64'h0,  0};

    // ---- reset held with a pending producer word ----
    drive(1'b1, 64'h77, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
      chk("rst_wr_en",     64'(bus.ram_wr_en), 64'd0);
      chk("rst_rd_en",     64'(bus.ram_rd_en), 64'd0);
      chk("rst_count",     64'(bus.count),     64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // ---- directed table: single word, then a stalled 3-word burst ----
    for (int v = 0; v < 14; v++) begin
      if (v != 0) @(negedge clk);
      drive(vecs[v].in_valid, vecs[v].in_data, vecs[v].out_ready);
      #1;
      chk($sformatf("v%0d_in_ready", v),  64'(bus.in_ready),  64'(vecs[v].e_in_ready));
      chk($sformatf("v%0d_wr_en", v),     64'(bus.ram_wr_en), 64'(vecs[v].e_wr_en));
      if (vecs[v].e_wr_en)
        chk($sformatf("v%0d_wr_ptr", v),  64'(bus.ram_wr_ptr), 64'(vecs[v].e_wr_ptr));
      chk($sformatf("v%0d_rd_en", v),     64'(bus.ram_rd_en), 64'(vecs[v].e_rd_en));
      if (vecs[v].e_rd_en)
        chk($sformatf("v%0d_rd_ptr", v),  64'(bus.ram_rd_ptr), 64'(vecs[v].e_rd_ptr));
      chk($sformatf("v%0d_out_valid", v), 64'(bus.out_valid), 64'(vecs[v].e_out_valid));
      if (vecs[v].e_out_valid)
        chk($sformatf("v%0d_out_data", v), bus.out_data, vecs[v].e_out_data);
      chk($sformatf("v%0d_count", v),     64'(bus.count),     64'(vecs[v].e_count));
    end

    // ---- fill to full with the consumer stalled ----
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      drive(1'b1, 64'(i), 1'b0);
      #1;
      chk("fill_count",    64'(bus.count),      64'(i));
      chk("fill_in_ready", 64'(bus.in_ready),   64'd1);
      chk("fill_wr_ptr",   64'(bus.ram_wr_ptr), 64'((4 + i) % 64));
    end
    @(negedge clk);
    drive(1'b1, 64'd64, 1'b0);
    #1;
    chk("full_count",     64'(bus.count),     64'd64);
    chk("full_in_ready",  64'(bus.in_ready),  64'd0);
    chk("full_wr_en",     64'(bus.ram_wr_en), 64'd0);
    chk("full_out_valid", 64'(bus.out_valid), 64'd1);
    chk("full_out_data",  bus.out_data,       64'd0);

    // ---- drain: one word per cycle, in order ----
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      drive(1'b0, 64'd0, 1'b1);
      #1;
      chk("drain_out_valid", 64'(bus.out_valid), 64'd1);
      chk("drain_out_data",  bus.out_data,       64'(i));
      if (i == 0) chk("drain_in_ready0", 64'(bus.in_ready), 64'd0);
      if (i == 1) chk("drain_in_ready1", 64'(bus.in_ready), 64'd1);
    end
    @(negedge clk); #1;
    chk("drained_out_valid", 64'(bus.out_valid), 64'd0);
    chk("drained_count",     64'(bus.count),     64'd0);

    // ---- streaming with both pointers wrapping three times ----
    n_out = 0;
    n_iss = 0;
    for (int i = 0; i < 220; i++) begin
      @(negedge clk);
      drive(i < 200, 64'(1000 + i), 1'b1);
      #1;
      if (i < 200) begin
        chk("strm_wr_en",  64'(bus.ram_wr_en),  64'd1);
        chk("strm_wr_ptr", 64'(bus.ram_wr_ptr), 64'((4 + i) % 64));
      end
      if (i >= 3 && i < 200) chk("strm_count", 64'(bus.count), 64'd3);
      if (i >= 3 && i < 203) chk("strm_out_valid", 64'(bus.out_valid), 64'd1);
      if (bus.ram_rd_en) begin
        chk("strm_rd_ptr", 64'(bus.ram_rd_ptr), 64'((4 + n_iss) % 64));
        n_iss++;
      end
      if (bus.out_valid) begin
        chk("strm_out_data", bus.out_data, 64'(1000 + n_out));
        n_out++;
      end
    end
    chk("strm_n_out", 64'(n_out),     64'd200);
    chk("strm_count_end", 64'(bus.count), 64'd0);

    // ---- random valid/ready against the expected queue ----
    stalled = 1'b0;
    held    = '0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
      #1;
      chk("rnd_count",    64'(bus.count),    64'(exp_q.size()));
      chk("rnd_in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 64));
      if (exp_q.size() == 0) chk("rnd_empty_valid", 64'(bus.out_valid), 64'd0);
      if (stalled) chk("rnd_hold", bus.out_data, held);
      if (bus.out_valid && exp_q.size() > 0) chk("rnd_out_data", bus.out_data, exp_q[0]);
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.out_data;
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
    end
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      drive(1'b0, 64'd0, 1'b1);
      #1;
      if (exp_q.size() == 0 && bus.count == 0) break;
      if (bus.out_valid && exp_q.size() > 0) begin
        chk("rnd_drain_data", bus.out_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
    chk("rnd_drain_count", 64'(bus.count),     64'd0);
    chk("rnd_drain_valid", 64'(bus.out_valid), 64'd0);

    // ---- reset with 10 words stored and a RAM read in flight ----
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, 64'(32'h500 + i), 1'b0);
      #1;
      chk("mid_fill_count", 64'(bus.count), 64'(i));
    end
    repeat (2) begin
      @(negedge clk);
      drive(1'b0, 64'd0, 1'b0);
    end
    @(negedge clk);
    drive(1'b1, 64'h50A, 1'b1);
    #1;
    chk("mid_rd_en",    64'(bus.ram_rd_en), 64'd1);
    chk("mid_count",    64'(bus.count),     64'd10);
    chk("mid_out_data", bus.out_data,       64'h500);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 64'd0, 1'b0);
    #1;
    chk("mid_rst_count",     64'(bus.count),     64'd0);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_in_ready",  64'(bus.in_ready),  64'd0);
    chk("mid_rst_rd_en",     64'(bus.ram_rd_en), 64'd0);
    chk("mid_rst_wr_en",     64'(bus.ram_wr_en), 64'd0);
    chk("mid_rst_out_data",  bus.out_data,       64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 64'h1, 1'b1);
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready),   64'd1);
    chk("post_rst_wr_ptr",   64'(bus.ram_wr_ptr), 64'd0);
    chk("post_rst_count",    64'(bus.count),      64'd0);
    got = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive(1'b0, 64'd0, 1'b1);
      #1;
      if (bus.out_valid) begin
        chk("post_rst_first_word", bus.out_data, 64'h1);
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("post_rst_timeout", 64'(got), 64'd1);
    @(negedge clk); #1;
    chk("post_rst_final_count", 64'(bus.count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
